// File: rtl/ysyx_23060077_lsu_ctrl.sv
// ysyx_23060077_lsu_ctrl
//   Load/store unit controller. Takes one load/store/none/sys operation from
//   the EXU, checks width and alignment, and issues at most one request on the
//   memory bus. It steers store lanes and strobes, then extends load data. The
//   result is returned to the WBU with an error flag.
//
// State table
//   IDLE | in_ready=1, waiting for an operation
//   REQ  | mem_req_valid=1, request fields held until mem_req_ready
//   WAIT | request accepted, waiting for the mem_rsp_valid pulse
//   RESP | out_valid=1, result held until out_ready
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready               EXU handshake
//   in_lsu_opt, in_funct3           operation and width/sign
//   in_addr, in_wdata               effective address, LSB-aligned store data
//   out_valid/out_ready             WBU handshake
//   out_rdata, out_err              extended load data, error flag
//   mem_req_valid/mem_req_ready     bus request handshake
//   mem_addr, mem_wen, mem_wdata,
//   mem_wstrb, mem_size             bus request fields
//   mem_rsp_valid, mem_rsp_rdata,
//   mem_rsp_err                     bus response
`ifndef LSU_OPT_WIDTH
`define LSU_OPT_WIDTH 2
`endif
`ifndef LSU_OPT_NONE
`define LSU_OPT_NONE 2'd0
`endif
`ifndef LSU_OPT_LOAD
`define LSU_OPT_LOAD 2'd1
`endif
`ifndef LSU_OPT_STORE
`define LSU_OPT_STORE 2'd2
`endif
`ifndef LSU_OPT_SYS
`define LSU_OPT_SYS 2'd3
`endif

module ysyx_23060077_lsu_ctrl #(
  parameter int XLEN = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [`LSU_OPT_WIDTH-1:0] in_lsu_opt,
  input  logic [2:0]                in_funct3,
  input  logic [XLEN-1:0]           in_addr,
  input  logic [XLEN-1:0]           in_wdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_rdata,
  output logic                      out_err,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [XLEN-1:0]           mem_addr,
  output logic                      mem_wen,
  output logic [XLEN-1:0]           mem_wdata,
  output logic [3:0]                mem_wstrb,
  output logic [1:0]                mem_size,
  input  logic                      mem_rsp_valid,
  input  logic [XLEN-1:0]           mem_rsp_rdata,
  input  logic                      mem_rsp_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [1:0]      size_q, size_d;
  logic            wen_q, wen_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            is_load, is_store;
  logic            f3_legal, misaligned, go_bus;
  logic [3:0]      strobe;
  logic [XLEN-1:0] wdata_rep;
  logic [XLEN-1:0] rsp_shifted;
  logic [XLEN-1:0] load_ext;

  assign is_load  = (in_lsu_opt == `LSU_OPT_LOAD);
  assign is_store = (in_lsu_opt == `LSU_OPT_STORE);

  always_comb begin
    f3_legal = 1'b0;
    if (is_load) begin
      f3_legal = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010) ||
                 (in_funct3 == 3'b100) || (in_funct3 == 3'b101);
    end else if (is_store) begin
      f3_legal = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010);
    end
  end

  assign misaligned = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                      ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
  assign go_bus     = f3_legal && !misaligned;

  always_comb begin
    strobe    = 4'b1111;
    wdata_rep = in_wdata;
    case (in_funct3[1:0])
      2'b00: begin
        strobe    = 4'b0001 << in_addr[1:0];
        wdata_rep = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        strobe    = 4'b0011 << in_addr[1:0];
        wdata_rep = {2{in_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Bus returns the whole word with lanes in place; bring the addressed lane to bit 0.
  assign rsp_shifted = mem_rsp_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_ext = rsp_shifted;
    case (funct3_q)
      3'b000:  load_ext = {{(XLEN-8){rsp_shifted[7]}}, rsp_shifted[7:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, rsp_shifted[7:0]};
      3'b001:  load_ext = {{(XLEN-16){rsp_shifted[15]}}, rsp_shifted[15:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, rsp_shifted[15:0]};
      default: load_ext = rsp_shifted;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    size_d   = size_q;
    wen_d    = wen_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          funct3_d = in_funct3;
          addr_d   = in_addr;
          wdata_d  = wdata_rep;
          wstrb_d  = is_store ? strobe : 4'b0000;
          size_d   = in_funct3[1:0];
          wen_d    = is_store;
          rdata_d  = '0;
          err_d    = 1'b0;
          if (go_bus) begin
            state_d = REQ;
          end else begin
            // NONE/SYS complete cleanly; a rejected load/store reports an error.
            state_d = RESP;
            err_d   = is_load || is_store;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          state_d = RESP;
          err_d   = mem_rsp_err;
          rdata_d = (mem_rsp_err || wen_q) ? '0 : load_ext;
        end
      end
      RESP: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= 4'b0000;
      size_q   <= 2'b00;
      wen_q    <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      size_q   <= size_d;
      wen_q    <= wen_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == RESP);
  assign out_rdata     = rdata_q;
  assign out_err       = err_q;
  assign mem_req_valid = (state_q == REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = wstrb_q;
  assign mem_size      = size_q;

endmodule

// File: tb/tb_ysyx_23060077_lsu_ctrl.sv
`ifndef LSU_OPT_WIDTH
`define LSU_OPT_WIDTH 2
`endif
`ifndef LSU_OPT_NONE
`define LSU_OPT_NONE 2'd0
`endif
`ifndef LSU_OPT_LOAD
`define LSU_OPT_LOAD 2'd1
`endif
`ifndef LSU_OPT_STORE
`define LSU_OPT_STORE 2'd2
`endif
`ifndef LSU_OPT_SYS
`define LSU_OPT_SYS 2'd3
`endif

module tb_ysyx_23060077_lsu_ctrl;

  logic                      clk;
  logic                      rst_n;
  logic                      in_valid;
  logic                      in_ready;
  logic [`LSU_OPT_WIDTH-1:0] in_lsu_opt;
  logic [2:0]                in_funct3;
  logic [31:0]               in_addr;
  logic [31:0]               in_wdata;
  logic                      out_valid;
  logic                      out_ready;
  logic [31:0]               out_rdata;
  logic                      out_err;
  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic [31:0]               mem_addr;
  logic                      mem_wen;
  logic [31:0]               mem_wdata;
  logic [3:0]                mem_wstrb;
  logic [1:0]                mem_size;
  logic                      mem_rsp_valid;
  logic [31:0]               mem_rsp_rdata;
  logic                      mem_rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_23060077_lsu_ctrl #(.XLEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_lsu_opt    (in_lsu_opt),
    .in_funct3     (in_funct3),
    .in_addr       (in_addr),
    .in_wdata      (in_wdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_rdata     (out_rdata),
    .out_err       (out_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_size      (mem_size),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .mem_rsp_err   (mem_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_rdata"}, out_rdata, 0);
    chk({tag, "_out_err"},   out_err, 0);
    chk({tag, "_req_valid"}, mem_req_valid, 0);
    chk({tag, "_mem_addr"},  mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_wen"},   mem_wen, 0);
    chk({tag, "_mem_wstrb"}, mem_wstrb, 0);
    chk({tag, "_mem_size"},  mem_size, 0);
  endtask

  // One full transaction: the reference model works from access size in bytes,
  // byte offsets and masks rather than from lane-select logic.
  task automatic txn(input string tag, input logic [1:0] opt, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rsp, input logic rerr,
                     input int rstall, input int ostall);
    bit          ld, st, legal, bus;
    int          nb, off;
    logic [31:0] mask, v, exp_rdata, exp_wdata;
    logic [3:0]  exp_wstrb;
    logic        exp_err;

    ld  = (opt == `LSU_OPT_LOAD);
    st  = (opt == `LSU_OPT_STORE);
    nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(addr % 4);
    if (ld)      legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    else if (st) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else         legal = 0;
    bus = legal && ((addr % nb) == 0);

    exp_wstrb = st ? 4'(((1 << nb) - 1) << off) : 4'd0;
    exp_wdata = (nb == 1) ? {24'd0, wdata[7:0]} * 32'h0101_0101 :
                (nb == 2) ? {16'd0, wdata[15:0]} * 32'h0001_0001 : wdata;

    if (!bus) begin
      exp_err   = ld || st;
      exp_rdata = 0;
    end else if (rerr || st) begin
      exp_err   = rerr;
      exp_rdata = 0;
    end else begin
      exp_err = 0;
      mask = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 1;
      v = (rsp >> (8 * off)) & mask;
      if (nb < 4 && !f3[2] && v[8*nb-1]) v = v | ~mask;
      exp_rdata = v;
    end

    chk({tag, "_in_ready"}, in_ready, 1);
    in_valid   = 1'b1;
    in_lsu_opt = opt;
    in_funct3  = f3;
    in_addr    = addr;
    in_wdata   = wdata;
    tick();
    in_valid = 1'b0;
    in_addr  = $urandom;
    in_wdata = $urandom;

    if (bus) begin
      chk({tag, "_ov_T1"},     out_valid, 0);
      chk({tag, "_req_valid"}, mem_req_valid, 1);
      chk({tag, "_mem_addr"},  mem_addr, addr);
      chk({tag, "_mem_wen"},   mem_wen, st);
      chk({tag, "_mem_wstrb"}, mem_wstrb, exp_wstrb);
      chk({tag, "_mem_size"},  mem_size, f3[1:0]);
      if (st) chk({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
      for (int i = 0; i < rstall; i++) begin
        tick();
        chk({tag, "_req_hold"},   mem_req_valid, 1);
        chk({tag, "_addr_hold"},  mem_addr, addr);
        chk({tag, "_wstrb_hold"}, mem_wstrb, exp_wstrb);
        if (st) chk({tag, "_wdata_hold"}, mem_wdata, exp_wdata);
      end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      chk({tag, "_req_drop"}, mem_req_valid, 0);
      chk({tag, "_ov_T2"},    out_valid, 0);
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = rsp;
      mem_rsp_err   = rerr;
      tick();
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = $urandom;
      mem_rsp_err   = 1'b0;
    end else begin
      chk({tag, "_no_req"}, mem_req_valid, 0);
    end

    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_out_rdata"}, out_rdata, exp_rdata);
    chk({tag, "_out_err"},   out_err, exp_err);
    chk({tag, "_in_busy"},   in_ready, 0);
    for (int i = 0; i < ostall; i++) begin
      tick();
      chk({tag, "_ov_hold"},  out_valid, 1);
      chk({tag, "_rd_hold"},  out_rdata, exp_rdata);
      chk({tag, "_err_hold"}, out_err, exp_err);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ov_drop"},  out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    in_lsu_opt    = `LSU_OPT_NONE;
    in_funct3     = 3'd0;
    in_addr       = 32'd0;
    in_wdata      = 32'd0;
    out_ready     = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'd0;
    mem_rsp_err   = 1'b0;
    repeat (2) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    txn("lb",      `LSU_OPT_LOAD,  3'b000, 32'h8000_0003, 32'd0,         32'h80AA_BBCC, 1'b0, 0, 0);
    txn("lhu",     `LSU_OPT_LOAD,  3'b101, 32'h8000_0002, 32'd0,         32'hF00D_1234, 1'b0, 0, 0);
    txn("lh",      `LSU_OPT_LOAD,  3'b001, 32'h8000_0002, 32'd0,         32'hF00D_1234, 1'b0, 0, 0);
    txn("sb",      `LSU_OPT_STORE, 3'b000, 32'h8000_0001, 32'h1234_56A5, 32'hDEAD_BEEF, 1'b0, 0, 0);
    txn("lw_mis",  `LSU_OPT_LOAD,  3'b010, 32'h8000_0002, 32'd0,         32'd0,         1'b0, 0, 0);
    txn("ld_f011", `LSU_OPT_LOAD,  3'b011, 32'h8000_0000, 32'd0,         32'd0,         1'b0, 0, 0);
    txn("sh_mis",  `LSU_OPT_STORE, 3'b001, 32'h8000_0003, 32'hAAAA_5555, 32'd0,         1'b0, 0, 0);
    txn("sbu_ill", `LSU_OPT_STORE, 3'b100, 32'h8000_0000, 32'h1,         32'd0,         1'b0, 0, 0);
    txn("none",    `LSU_OPT_NONE,  3'b010, 32'h8000_0001, 32'd0,         32'd0,         1'b0, 0, 1);
    txn("sys",     `LSU_OPT_SYS,   3'b000, 32'h0,         32'd0,         32'd0,         1'b0, 0, 0);
    txn("lw",      `LSU_OPT_LOAD,  3'b010, 32'h8000_0010, 32'd0,         32'h1357_9BDF, 1'b0, 0, 0);
    txn("sw_bp",   `LSU_OPT_STORE, 3'b010, 32'h8000_0104, 32'hCAFE_F00D, 32'd0,         1'b1, 5, 3);
    txn("lb_err",  `LSU_OPT_LOAD,  3'b100, 32'h8000_0002, 32'd0,         32'hFFFF_FFFF, 1'b1, 1, 0);
    txn("sh_hi",   `LSU_OPT_STORE, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 32'd0,         1'b0, 0, 0);

    // Reset while waiting for the response.
    in_valid   = 1'b1;
    in_lsu_opt = `LSU_OPT_LOAD;
    in_funct3  = 3'b010;
    in_addr    = 32'h8000_0020;
    tick();
    in_valid      = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_wait");
    tick();
    rst_n         = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h1111_2222;
    tick();
    mem_rsp_valid = 1'b0;
    chk("stray_ov", out_valid, 0);
    chk("stray_ir", in_ready, 1);
    txn("lw_post", `LSU_OPT_LOAD, 3'b010, 32'h8000_0040, 32'd0, 32'h2468_ACE0, 1'b0, 0, 0);

    for (int k = 0; k < 60; k++) begin
      logic [1:0]  r_opt;
      logic [2:0]  r_f3;
      logic [31:0] r_addr;
      r_opt  = 2'($urandom_range(0, 3));
      r_f3   = 3'($urandom_range(0, 7));
      r_addr = $urandom;
      if ($urandom_range(0, 1) == 0) r_f3 = {r_f3[2], 1'b0, r_f3[0]};
      txn("rnd", r_opt, r_f3, r_addr, $urandom, $urandom,
          1'($urandom_range(0, 3) == 0), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
